// File: rtl/axi_burst_master_pkg.sv
// Shared encodings, state enum and the 4KB page rule for the AXI burst master.
package axi_burst_master_pkg;

  localparam logic [1:0] BURST_INCR = 2'h1;
  localparam logic [2:0] SIZE_8B    = 3'h3;
  localparam logic [1:0] RESP_OKAY  = 2'h0;

  localparam int unsigned PAGE_BYTES = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_RSP
  } state_e;

  // offs is the page offset of a beat-aligned start address; a burst may end exactly on the page edge.
  function automatic logic crosses_4k(input logic [11:0] offs, input logic [7:0] len);
    logic [13:0] end_b;
    end_b = {2'b00, offs} + (({6'b0, len} + 14'd1) << 3);
    return end_b > 14'(PAGE_BYTES);
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// Core-side request/data streams plus the full AXI4 master port of the burst master.
interface axi_burst_master_if #(
  parameter int AXI_ADDR_W = 64,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 64
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wen;
  logic [AXI_ADDR_W-1:0]   req_addr;
  logic [7:0]              req_len;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [AXI_DATA_W-1:0]   wr_data;
  logic [AXI_DATA_W/8-1:0] wr_strb;

  logic                    rd_valid;
  logic                    rd_ready;
  logic [AXI_DATA_W-1:0]   rd_data;
  logic                    rd_last;

  logic                    resp_valid;
  logic                    resp_err;

  logic                    slv_awvalid;
  logic                    slv_awready;
  logic [AXI_ADDR_W-1:0]   slv_awaddr;
  logic [7:0]              slv_awlen;
  logic [2:0]              slv_awsize;
  logic [1:0]              slv_awburst;
  logic                    slv_awlock;
  logic [3:0]              slv_awcache;
  logic [2:0]              slv_awprot;
  logic [3:0]              slv_awqos;
  logic [3:0]              slv_awregion;
  logic [AXI_ID_W-1:0]     slv_awid;

  logic                    slv_wvalid;
  logic                    slv_wready;
  logic                    slv_wlast;
  logic [AXI_DATA_W-1:0]   slv_wdata;
  logic [AXI_DATA_W/8-1:0] slv_wstrb;

  logic                    slv_bvalid;
  logic                    slv_bready;
  logic [AXI_ID_W-1:0]     slv_bid;
  logic [1:0]              slv_bresp;

  logic                    slv_arvalid;
  logic                    slv_arready;
  logic [AXI_ADDR_W-1:0]   slv_araddr;
  logic [7:0]              slv_arlen;
  logic [2:0]              slv_arsize;
  logic [1:0]              slv_arburst;
  logic                    slv_arlock;
  logic [3:0]              slv_arcache;
  logic [2:0]              slv_arprot;
  logic [3:0]              slv_arqos;
  logic [3:0]              slv_arregion;
  logic [AXI_ID_W-1:0]     slv_arid;

  logic                    slv_rvalid;
  logic                    slv_rready;
  logic [AXI_ID_W-1:0]     slv_rid;
  logic [AXI_DATA_W-1:0]   slv_rdata;
  logic [1:0]              slv_rresp;
  logic                    slv_rlast;

  // master: the burst master itself; slave: everything around it (clients and fabric).
  modport master (
    input  req_valid, req_wen, req_addr, req_len,
    output req_ready,
    input  wr_valid, wr_data, wr_strb,
    output wr_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    output resp_valid, resp_err,
    output slv_awvalid, slv_awaddr, slv_awlen, slv_awsize, slv_awburst, slv_awlock,
           slv_awcache, slv_awprot, slv_awqos, slv_awregion, slv_awid,
    input  slv_awready,
    output slv_wvalid, slv_wlast, slv_wdata, slv_wstrb,
    input  slv_wready,
    input  slv_bvalid, slv_bid, slv_bresp,
    output slv_bready,
    output slv_arvalid, slv_araddr, slv_arlen, slv_arsize, slv_arburst, slv_arlock,
           slv_arcache, slv_arprot, slv_arqos, slv_arregion, slv_arid,
    input  slv_arready,
    input  slv_rvalid, slv_rid, slv_rdata, slv_rresp, slv_rlast,
    output slv_rready
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_len,
    input  req_ready,
    output wr_valid, wr_data, wr_strb,
    input  wr_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    input  resp_valid, resp_err,
    input  slv_awvalid, slv_awaddr, slv_awlen, slv_awsize, slv_awburst, slv_awlock,
           slv_awcache, slv_awprot, slv_awqos, slv_awregion, slv_awid,
    output slv_awready,
    input  slv_wvalid, slv_wlast, slv_wdata, slv_wstrb,
    output slv_wready,
    output slv_bvalid, slv_bid, slv_bresp,
    input  slv_bready,
    input  slv_arvalid, slv_araddr, slv_arlen, slv_arsize, slv_arburst, slv_arlock,
           slv_arcache, slv_arprot, slv_arqos, slv_arregion, slv_arid,
    output slv_arready,
    output slv_rvalid, slv_rid, slv_rdata, slv_rresp, slv_rlast,
    input  slv_rready
  );

endinterface

// File: rtl/axi_burst_master_beat_cnt.sv
// Beat counter shared by the R and W phases; last flags the beat whose index equals len.
module axi_burst_master_beat_cnt
  import axi_burst_master_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] len,
  output logic       last
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (inc) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == len);

endmodule

// File: rtl/axi_burst_master.sv
// Turns one core-side memory request into a single AXI4 INCR burst of 8-byte beats.
module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int                  AXI_ADDR_W = 64,
  parameter int                  AXI_ID_W   = 8,
  parameter int                  AXI_DATA_W = 64,
  parameter logic [AXI_ID_W-1:0] TXN_ID     = '0
) (
  input logic                aclk,
  input logic                arst,
  axi_burst_master_if.master bus
);

  state_e                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic                  err_q, err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  awvalid_q, awvalid_d;
  logic                  bready_q, bready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;

  logic                  in_r, in_w;
  logic                  accept, ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic                  beat_last;
  logic [AXI_ADDR_W-1:0] req_addr_al;

  assign req_addr_al = bus.req_addr & {{(AXI_ADDR_W-3){1'b1}}, 3'b000};

  assign in_r   = (state_q == S_R);
  assign in_w   = (state_q == S_W);
  assign accept = (state_q == S_IDLE) && req_ready_q && bus.req_valid;
  assign ar_hs  = (state_q == S_AR) && arvalid_q && bus.slv_arready;
  assign aw_hs  = (state_q == S_AW) && awvalid_q && bus.slv_awready;
  assign r_hs   = in_r && bus.slv_rvalid && bus.rd_ready;
  assign w_hs   = in_w && bus.wr_valid && bus.slv_wready;
  assign b_hs   = (state_q == S_B) && bready_q && bus.slv_bvalid;

  axi_burst_master_beat_cnt u_beat_cnt (
    .clk  (aclk),
    .rst  (arst),
    .clr  (ar_hs | aw_hs),
    .inc  (r_hs | w_hs),
    .len  (len_q),
    .last (beat_last)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = req_addr_al;
          len_d  = bus.req_len;
          err_d  = 1'b0;
          // Page-crossing bursts are refused locally and never reach the fabric.
          if (crosses_4k(req_addr_al[11:0], bus.req_len)) begin
            err_d   = 1'b1;
            state_d = S_RSP;
          end else begin
            state_d = bus.req_wen ? S_AW : S_AR;
          end
        end
      end
      S_AR: if (ar_hs) state_d = S_R;
      S_R: begin
        if (r_hs) begin
          if ((bus.slv_rresp != RESP_OKAY) || (bus.slv_rid != TXN_ID) ||
              (bus.slv_rlast != beat_last)) begin
            err_d = 1'b1;
          end
          // An early rlast from the slave still ends the burst.
          if (beat_last || bus.slv_rlast) state_d = S_RSP;
        end
      end
      S_AW: if (aw_hs) state_d = S_W;
      S_W:  if (w_hs && beat_last) state_d = S_B;
      S_B: begin
        if (b_hs) begin
          if ((bus.slv_bresp != RESP_OKAY) || (bus.slv_bid != TXN_ID)) err_d = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    arvalid_d    = (state_d == S_AR);
    awvalid_d    = (state_d == S_AW);
    bready_d     = (state_d == S_B);
    resp_valid_d = (state_d == S_RSP);
    resp_err_d   = (state_d == S_RSP) && err_d;
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= 8'd0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      awvalid_q    <= awvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;

  assign bus.slv_arvalid  = arvalid_q;
  assign bus.slv_araddr   = addr_q;
  assign bus.slv_arlen    = len_q;
  assign bus.slv_arsize   = SIZE_8B;
  assign bus.slv_arburst  = BURST_INCR;
  assign bus.slv_arlock   = 1'b0;
  assign bus.slv_arcache  = 4'h0;
  assign bus.slv_arprot   = 3'h0;
  assign bus.slv_arqos    = 4'h0;
  assign bus.slv_arregion = 4'h0;
  assign bus.slv_arid     = TXN_ID;

  assign bus.slv_awvalid  = awvalid_q;
  assign bus.slv_awaddr   = addr_q;
  assign bus.slv_awlen    = len_q;
  assign bus.slv_awsize   = SIZE_8B;
  assign bus.slv_awburst  = BURST_INCR;
  assign bus.slv_awlock   = 1'b0;
  assign bus.slv_awcache  = 4'h0;
  assign bus.slv_awprot   = 3'h0;
  assign bus.slv_awqos    = 4'h0;
  assign bus.slv_awregion = 4'h0;
  assign bus.slv_awid     = TXN_ID;

  // Data phases are pure pass-through, gated by state so nothing leaks outside a burst.
  assign bus.rd_valid   = in_r && bus.slv_rvalid;
  assign bus.rd_data    = in_r ? bus.slv_rdata : {AXI_DATA_W{1'b0}};
  assign bus.rd_last    = in_r && beat_last;
  assign bus.slv_rready = in_r && bus.rd_ready;

  assign bus.slv_wvalid = in_w && bus.wr_valid;
  assign bus.slv_wdata  = in_w ? bus.wr_data : {AXI_DATA_W{1'b0}};
  assign bus.slv_wstrb  = in_w ? bus.wr_strb : {(AXI_DATA_W/8){1'b0}};
  assign bus.slv_wlast  = in_w && beat_last;
  assign bus.wr_ready   = in_w && bus.slv_wready;

  assign bus.slv_bready = bready_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: reads, writes, error responses, 4KB refusal, mid-burst reset.
module tb_axi_burst_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_burst_master_if bus ();

  axi_burst_master dut (
    .aclk (clk),
    .arst (rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] wdat [4];
  logic [7:0]  wstb [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send_req(input logic wen, input logic [63:0] addr, input logic [7:0] len);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_len   = len;
    #1 chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    cyc();
    bus.req_valid = 1'b0;
  endtask

  task automatic addr_phase(input logic wen, input logic [63:0] exp_addr, input logic [7:0] exp_len);
    if (wen) begin
      bus.slv_awready = 1'b1;
      bus.wr_valid    = 1'b1;
      bus.wr_data     = wdat[0];
      bus.wr_strb     = wstb[0];
      bus.slv_wready  = 1'b1;
      #1;
      chk("awvalid", 64'(bus.slv_awvalid), 64'd1);
      chk("awaddr", bus.slv_awaddr, exp_addr);
      chk("awlen", 64'(bus.slv_awlen), 64'(exp_len));
      chk("aw_size_burst_id", 64'({bus.slv_awsize, bus.slv_awburst, bus.slv_awid}), 64'h0d00);
      chk("aw_side", 64'({bus.slv_awlock, bus.slv_awcache, bus.slv_awprot, bus.slv_awqos, bus.slv_awregion}), 64'd0);
      chk("arvalid_in_aw", 64'(bus.slv_arvalid), 64'd0);
      chk("wr_ready_before_aw", 64'(bus.wr_ready), 64'd0);
      chk("wvalid_before_aw", 64'(bus.slv_wvalid), 64'd0);
    end else begin
      bus.slv_arready = 1'b1;
      #1;
      chk("arvalid", 64'(bus.slv_arvalid), 64'd1);
      chk("araddr", bus.slv_araddr, exp_addr);
      chk("arlen", 64'(bus.slv_arlen), 64'(exp_len));
      chk("ar_size_burst_id", 64'({bus.slv_arsize, bus.slv_arburst, bus.slv_arid}), 64'h0d00);
      chk("ar_side", 64'({bus.slv_arlock, bus.slv_arcache, bus.slv_arprot, bus.slv_arqos, bus.slv_arregion}), 64'd0);
      chk("awvalid_in_ar", 64'(bus.slv_awvalid), 64'd0);
    end
    cyc();
    bus.slv_arready = 1'b0;
    bus.slv_awready = 1'b0;
    #1 chk("addr_valid_dropped", 64'({bus.slv_arvalid, bus.slv_awvalid}), 64'd0);
  endtask

  task automatic read_beats(input int len, input bit toggle, input logic [63:0] base);
    int i = 0;
    int c = 0;
    while (i <= len && c < 200) begin
      bus.slv_rvalid = 1'b1;
      bus.slv_rdata  = base + 64'(i);
      bus.slv_rlast  = (i == len);
      bus.slv_rresp  = 2'h0;
      bus.slv_rid    = 8'h00;
      bus.rd_ready   = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      chk("rready_mirror", 64'(bus.slv_rready), 64'(bus.rd_ready));
      chk("rd_valid", 64'(bus.rd_valid), 64'd1);
      chk("rd_data", bus.rd_data, base + 64'(i));
      chk("rd_last", 64'(bus.rd_last), 64'(i == len));
      if (bus.rd_ready) i++;
      c++;
      cyc();
    end
    chk("rd_beats", 64'(i), 64'(len + 1));
    bus.slv_rvalid = 1'b0;
    bus.slv_rlast  = 1'b0;
    bus.rd_ready   = 1'b1;
  endtask

  task automatic write_beats(input int len);
    for (int i = 0; i <= len; i++) begin
      bus.wr_valid   = 1'b1;
      bus.wr_data    = wdat[i];
      bus.wr_strb    = wstb[i];
      bus.slv_wready = 1'b1;
      #1;
      chk("wvalid", 64'(bus.slv_wvalid), 64'd1);
      chk("wdata", bus.slv_wdata, wdat[i]);
      chk("wstrb", 64'(bus.slv_wstrb), 64'(wstb[i]));
      chk("wlast", 64'(bus.slv_wlast), 64'(i == len));
      chk("wr_ready", 64'(bus.wr_ready), 64'd1);
      cyc();
    end
    bus.wr_valid   = 1'b0;
    bus.slv_wready = 1'b0;
  endtask

  task automatic b_phase(input logic [1:0] resp);
    bus.slv_bvalid = 1'b1;
    bus.slv_bresp  = resp;
    bus.slv_bid    = 8'h00;
    #1;
    chk("bready", 64'(bus.slv_bready), 64'd1);
    chk("resp_valid_in_b", 64'(bus.resp_valid), 64'd0);
    cyc();
    bus.slv_bvalid = 1'b0;
    bus.slv_bresp  = 2'h0;
  endtask

  task automatic finish_rsp(input logic exp_err);
    #1;
    chk("resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("resp_err", 64'(bus.resp_err), 64'(exp_err));
    chk("req_ready_in_rsp", 64'(bus.req_ready), 64'd0);
    cyc();
    #1;
    chk("resp_valid_pulse", 64'(bus.resp_valid), 64'd0);
    chk("req_ready_after_rsp", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_wen     = 1'b0;
    bus.req_addr    = 64'd0;
    bus.req_len     = 8'd0;
    bus.wr_valid    = 1'b0;
    bus.wr_data     = 64'd0;
    bus.wr_strb     = 8'd0;
    bus.rd_ready    = 1'b1;
    bus.slv_awready = 1'b0;
    bus.slv_wready  = 1'b0;
    bus.slv_bvalid  = 1'b0;
    bus.slv_bid     = 8'h00;
    bus.slv_bresp   = 2'h0;
    bus.slv_arready = 1'b0;
    bus.slv_rvalid  = 1'b1;
    bus.slv_rid     = 8'h00;
    bus.slv_rdata   = 64'hDEAD_BEEF_0000_0001;
    bus.slv_rresp   = 2'h0;
    bus.slv_rlast   = 1'b0;
    wdat[0] = 64'h1111_2222_3333_4444; wstb[0] = 8'hFF;
    wdat[1] = 64'hAAAA_BBBB_CCCC_DDDD; wstb[1] = 8'h0F;
    wdat[2] = 64'd0;                   wstb[2] = 8'h00;
    wdat[3] = 64'd0;                   wstb[3] = 8'h00;

    // Reset state
    cyc(); cyc();
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_valids", 64'({bus.slv_arvalid, bus.slv_awvalid, bus.slv_wvalid, bus.slv_bready,
                           bus.slv_rready, bus.rd_valid, bus.wr_ready, bus.resp_valid}), 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
    chk("rst_addr", bus.slv_araddr | bus.slv_awaddr, 64'd0);
    chk("rst_len", 64'({bus.slv_arlen, bus.slv_awlen}), 64'd0);
    chk("rst_rd_data", bus.rd_data, 64'd0);
    rst = 1'b0;
    bus.slv_rvalid = 1'b0;
    cyc();

    // Read 4 beats, always-ready peers
    send_req(1'b0, 64'h0000_0000_8000_0000, 8'd3);
    addr_phase(1'b0, 64'h0000_0000_8000_0000, 8'd3);
    read_beats(3, 1'b0, 64'h0000_0000_0000_1000);
    finish_rsp(1'b0);

    // Write 2 beats with partial strobe on the second
    send_req(1'b1, 64'h0000_0000_8000_0100, 8'd1);
    addr_phase(1'b1, 64'h0000_0000_8000_0100, 8'd1);
    write_beats(1);
    b_phase(2'h0);
    finish_rsp(1'b0);

    // Read 8 beats with rd_ready toggling every cycle
    send_req(1'b0, 64'h0000_0000_8000_0200, 8'd7);
    addr_phase(1'b0, 64'h0000_0000_8000_0200, 8'd7);
    read_beats(7, 1'b1, 64'h0000_0000_0000_2000);
    finish_rsp(1'b0);

    // SLVERR write response, then an OKAY read clears the error
    send_req(1'b1, 64'h0000_0000_8000_0300, 8'd0);
    addr_phase(1'b1, 64'h0000_0000_8000_0300, 8'd0);
    write_beats(0);
    b_phase(2'h2);
    finish_rsp(1'b1);
    send_req(1'b0, 64'h0000_0000_8000_0400, 8'd0);
    addr_phase(1'b0, 64'h0000_0000_8000_0400, 8'd0);
    read_beats(0, 1'b0, 64'h0000_0000_0000_3000);
    finish_rsp(1'b0);

    // Burst crossing a 4KB page: refused, no address phase
    send_req(1'b0, 64'h0000_0000_8000_0FF8, 8'd1);
    #1 chk("no_addr_on_4k", 64'({bus.slv_arvalid, bus.slv_awvalid}), 64'd0);
    finish_rsp(1'b1);

    // Burst ending exactly on the page edge is legal
    send_req(1'b0, 64'h0000_0000_8000_0FF8, 8'd0);
    addr_phase(1'b0, 64'h0000_0000_8000_0FF8, 8'd0);
    read_beats(0, 1'b0, 64'h0000_0000_0000_4000);
    finish_rsp(1'b0);

    // Reset during the 3rd beat of an 8-beat read
    send_req(1'b0, 64'h0000_0000_8000_1000, 8'd7);
    addr_phase(1'b0, 64'h0000_0000_8000_1000, 8'd7);
    for (int i = 0; i < 2; i++) begin
      bus.slv_rvalid = 1'b1;
      bus.slv_rdata  = 64'h5000 + 64'(i);
      bus.slv_rlast  = 1'b0;
      bus.rd_ready   = 1'b1;
      cyc();
    end
    bus.slv_rdata = 64'h5002;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("arst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("arst_rready", 64'(bus.slv_rready), 64'd0);
    chk("arst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("arst_other_valids", 64'({bus.slv_arvalid, bus.slv_awvalid, bus.slv_wvalid,
                                  bus.slv_bready, bus.resp_valid}), 64'd0);
    bus.slv_rvalid = 1'b0;
    cyc();

    // Fresh read after reset; unaligned request address is beat-aligned
    send_req(1'b0, 64'h0000_0000_8000_0203, 8'd2);
    addr_phase(1'b0, 64'h0000_0000_8000_0200, 8'd2);
    read_beats(2, 1'b0, 64'h0000_0000_0000_6000);
    finish_rsp(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
